// File: rtl/klingon_pkg.sv
// Shared Klingon glyph definitions: segment table, result payload and encoder FSM states.
package klingon_pkg;

  localparam int unsigned SEG_W     = 7;
  localparam int unsigned DIGIT_W   = 4;
  localparam int unsigned CNT_W     = 8;
  localparam int unsigned NUM_GLYPH = 10;

  localparam logic [DIGIT_W-1:0] DIGIT_ERR = 4'hF;
  localparam logic [SEG_W-1:0]   SEG_BLANK = 7'h00;

  // Segment pattern for each digit, bit0=a .. bit6=g.
  localparam logic [SEG_W-1:0] KLINGON_GLYPH [0:NUM_GLYPH-1] = '{
    7'h3F, 7'h30, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    EMIT,
    WAIT_CHANGE
  } klingon_state_e;

  typedef struct packed {
    logic               err;
    logic [DIGIT_W-1:0] digit;
  } glyph_res_t;

  // Reverse table lookup; unknown patterns map to DIGIT_ERR with err set.
  function automatic glyph_res_t glyph_lookup(input logic [SEG_W-1:0] seg);
    glyph_res_t r;
    r.err   = 1'b1;
    r.digit = DIGIT_ERR;
    for (int i = 0; i < int'(NUM_GLYPH); i++) begin
      if (seg == KLINGON_GLYPH[i]) begin
        r.err   = 1'b0;
        r.digit = DIGIT_W'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/klingon_sync.sv
// Multi-bit flop-chain synchronizer for a quasi-static asynchronous bus.
module klingon_sync #(
  parameter int unsigned WIDTH  = 7,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(STAGES); i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < int'(STAGES); i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/klingon_glyph_encoder.sv
// Recovers a Klingon digit from a debounced front-panel segment pattern and
// hands each newly stable glyph downstream once over a valid/ready port.
module klingon_glyph_encoder
  import klingon_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [SEG_W-1:0]   seg_in,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [DIGIT_W-1:0] out_digit,
  output logic               out_err,
  output logic               overrun
);

  // A single stable sample is enough when STABLE_CYCLES is 1, so skip SETTLE.
  localparam klingon_state_e LOAD_STATE = (STABLE_CYCLES <= 1) ? EMIT : SETTLE;

  logic [SEG_W-1:0] seg_s;
  logic [SEG_W-1:0] seg_q;
  klingon_state_e   state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             last_c;
  glyph_res_t       res_c;

  klingon_sync #(
    .WIDTH (SEG_W),
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (seg_in),
    .q    (seg_s)
  );

  assign last_c = (9'(cnt) + 9'd1) >= 9'(STABLE_CYCLES);
  assign res_c  = glyph_lookup(seg_q);

  // Next-state and debounce counter.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (seg_s != SEG_BLANK) begin
          cnt_nxt   = CNT_W'(1);
          state_nxt = LOAD_STATE;
        end
      end
      SETTLE: begin
        if (seg_s != seg_q) begin
          if (seg_s == SEG_BLANK) begin
            state_nxt = IDLE;
          end else begin
            cnt_nxt   = CNT_W'(1);
            state_nxt = LOAD_STATE;
          end
        end else if (last_c) begin
          state_nxt = EMIT;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      EMIT: begin
        state_nxt = WAIT_CHANGE;
      end
      WAIT_CHANGE: begin
        if (seg_s != seg_q) begin
          if (seg_s == SEG_BLANK) begin
            state_nxt = IDLE;
          end else begin
            cnt_nxt   = CNT_W'(1);
            state_nxt = LOAD_STATE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      seg_q <= SEG_BLANK;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      seg_q <= seg_s;
    end
  end

  // Result register: a new result may replace one leaving this cycle, else it is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_digit <= '0;
      out_err   <= 1'b0;
      overrun   <= 1'b0;
    end else if (state == EMIT) begin
      if (!out_valid || out_ready) begin
        out_valid <= 1'b1;
        out_digit <= res_c.digit;
        out_err   <= res_c.err;
      end else begin
        overrun <= 1'b1;
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_klingon_glyph_encoder.sv
// Directed and randomized checks of klingon_glyph_encoder against a run-length
// reference model of the segment stream.
module tb_klingon_glyph_encoder;

  localparam int unsigned STABLE = 4;
  localparam int unsigned SYNC   = 2;
  localparam int unsigned LAT    = SYNC + STABLE + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] seg_in = 7'h00;
  logic       out_ready = 1'b1;
  logic       out_valid;
  logic [3:0] out_digit;
  logic       out_err;
  logic       overrun;

  klingon_glyph_encoder #(
    .STABLE_CYCLES(STABLE),
    .SYNC_STAGES  (SYNC)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .seg_in   (seg_in),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_digit(out_digit),
    .out_err  (out_err),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Every accepted transfer, as {err,digit}, with the edge count it appeared after.
  logic [4:0]  got_q[$];
  int unsigned got_cyc[$];
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      got_q.push_back({out_err, out_digit});
      got_cyc.push_back(cyc);
    end
  end

  logic [6:0] ref_glyph [10] = '{7'h3F, 7'h30, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [4:0] ref_lookup(input logic [6:0] seg);
    for (int i = 0; i < 10; i++)
      if (ref_glyph[i] == seg) return {1'b0, 4'(i)};
    return {1'b1, 4'hF};
  endfunction

  task automatic clear_mon();
    got_q.delete();
    got_cyc.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_digit"}, 32'(out_digit), 32'd0);
    check({tag, "_err"}, 32'(out_err), 32'd0);
    check({tag, "_ovr"}, 32'(overrun), 32'd0);
  endtask

  task automatic apply_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check_reset_outputs(tag);
    step(2);
    rst_n = 1'b1;
  endtask

  // Expect exactly one transfer carrying exp, optionally LAT edges after t0.
  task automatic check_single(input string tag, input logic [4:0] exp,
                              input bit chk_lat, input int unsigned t0);
    logic [4:0]  r;
    int unsigned lat;
    r   = (got_q.size() > 0) ? got_q[0] : 5'h1E;
    lat = (got_cyc.size() > 0) ? got_cyc[0] - t0 : 0;
    check({tag, "_count"}, 32'(got_q.size()), 32'd1);
    check({tag, "_data"}, 32'(r), 32'(exp));
    if (chk_lat) check({tag, "_lat"}, lat, LAT);
  endtask

  initial begin
    int unsigned t0;
    logic [6:0]  prev;
    logic [6:0]  v;
    int          len;
    logic [4:0]  exp_q[$];

    // Clean step: one result, fixed latency.
    out_ready = 1'b1;
    seg_in    = 7'h00;
    apply_reset("rst0");
    step(5);
    clear_mon();
    t0     = cyc;
    seg_in = 7'h5B;
    step(20);
    check_single("step2", {1'b0, 4'd2}, 1'b1, t0);
    seg_in = 7'h00;
    step(10);

    // Bouncing input must not emit until it holds.
    clear_mon();
    for (int i = 0; i < 10; i++) begin
      seg_in = (i % 2 == 0) ? 7'h4F : 7'h66;
      step(3);
    end
    check("toggle_quiet", 32'(got_q.size()), 32'd0);
    seg_in = 7'h66;
    step(20);
    check_single("toggle_hold", {1'b0, 4'd4}, 1'b0, 0);
    seg_in = 7'h00;
    step(10);

    // Pattern outside the table.
    clear_mon();
    seg_in = 7'h01;
    step(15);
    check_single("bad_glyph", {1'b1, 4'hF}, 1'b0, 0);
    seg_in = 7'h00;
    step(10);

    // Stalled output: second result dropped, overrun sticky.
    clear_mon();
    out_ready = 1'b0;
    seg_in    = 7'h3F;
    step(10);
    seg_in = 7'h00;
    step(5);
    seg_in = 7'h07;
    step(12);
    check("stall_valid", 32'(out_valid), 32'd1);
    check("stall_digit", 32'(out_digit), 32'd0);
    check("stall_err", 32'(out_err), 32'd0);
    check("stall_ovr", 32'(overrun), 32'd1);
    check("stall_none", 32'(got_q.size()), 32'd0);
    out_ready = 1'b1;
    step(1);
    check("drain_valid", 32'(out_valid), 32'd0);
    check_single("drain", {1'b0, 4'd0}, 1'b0, 0);
    check("drain_ovr", 32'(overrun), 32'd1);
    seg_in = 7'h00;
    step(10);
    apply_reset("rst1");
    step(5);

    // Sweep the whole table.
    clear_mon();
    for (int d = 0; d < 10; d++) begin
      seg_in = ref_glyph[d];
      step(10);
      seg_in = 7'h00;
      step(6);
    end
    check("sweep_count", 32'(got_q.size()), 32'd10);
    for (int d = 0; d < 10; d++)
      if (d < got_q.size()) check($sformatf("sweep_%0d", d), 32'(got_q[d]), 32'(d));
    check("sweep_ovr", 32'(overrun), 32'd0);

    // Reset during SETTLE, then the held glyph is new after release.
    seg_in = 7'h6D;
    step(4);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_settle");
    step(2);
    clear_mon();
    t0    = cyc;
    rst_n = 1'b1;
    step(20);
    check_single("rel_settle", {1'b0, 4'd5}, 1'b1, t0);

    // Reset while a result is pending.
    out_ready = 1'b0;
    seg_in    = 7'h7F;
    step(12);
    check("pend_valid", 32'(out_valid), 32'd1);
    check("pend_digit", 32'(out_digit), 32'd8);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_pend");
    step(2);
    out_ready = 1'b1;
    clear_mon();
    t0    = cyc;
    rst_n = 1'b1;
    step(20);
    check_single("rel_pend", {1'b0, 4'd8}, 1'b1, t0);
    seg_in = 7'h00;
    step(10);

    // Random segment runs: each nonzero run of at least STABLE samples yields one result.
    apply_reset("rst2");
    step(3);
    clear_mon();
    prev = 7'h00;
    for (int s = 0; s < 60; s++) begin
      do begin
        case ($urandom_range(0, 9))
          0, 1:    v = 7'h00;
          8, 9:    v = 7'($urandom);
          default: v = ref_glyph[$urandom_range(0, 9)];
        endcase
      end while (v == prev);
      len = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(5, 12));
      if (v != 7'h00 && len >= int'(STABLE)) exp_q.push_back(ref_lookup(v));
      seg_in = v;
      step(len);
      prev = v;
    end
    seg_in = 7'h00;
    step(12);
    check("rand_count", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got_q.size()) check($sformatf("rand_%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
    check("rand_ovr", 32'(overrun), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
